// File: rtl/int_pkg.sv
// int_pkg: shared FSM states, CP0 register numbers and interrupt layout constants
package int_pkg;
    typedef enum logic [2:0] {IDLE, REQ, SAVE_EPC, SAVE_CAUSE, SERVICE} state_t;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam int         CAUSE_IP_LSB = 8;
    localparam int         VEC_STRIDE   = 16;
endpackage

// File: rtl/int_ctrl_irq_edge_sync.sv
// irq_edge_sync: two-flop synchronizer plus rising-edge detector for one interrupt line
module irq_edge_sync (
    input  logic clk,
    input  logic clr_n,
    input  logic i_irq,
    output logic o_rise
);
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [2:0] r_arm;
    // Synchronize the line; r_arm masks edges until every stage holds a real sample,
    // so a line already high at reset release never looks like a fresh edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_arm <= '0;
        end else begin
            r_s1  <= i_irq;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_arm <= {r_arm[1:0], 1'b1};
        end
    end
    assign o_rise = r_arm[2] & r_s2 & ~r_s3;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: prioritized interrupt controller that saves EPC/Cause to CP0 and tracks service
module int_ctrl
    import int_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               N_IRQ    = 4,
    parameter logic [WIDTH-1:0] VEC_BASE = 32'h0000_0800
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic             IE_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [WIDTH-1:0] int_vector,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [WIDTH-1:0] cp0_din,
    output logic             IE_zero,
    output logic             IE_one,
    output logic [N_IRQ-1:0] in_service
);
    localparam int SW = N_IRQ > 1 ? $clog2(N_IRQ) : 1;
    state_t           r_state;
    state_t           w_next;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_sel_oh;
    logic [SW-1:0]    r_sel;
    logic [SW-1:0]    w_low;
    logic [WIDTH-1:0] r_epc;
    logic             w_ack;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk    (clk),
            .clr_n  (clr_n),
            .i_irq  (irq[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_ack    = (r_state == REQ) && int_ack;
    assign w_sel_oh = N_IRQ'(1) << r_sel;
    assign w_clr    = w_ack ? w_sel_oh : '0;

    // Lowest set pending bit wins (irq[0] highest priority).
    always_comb begin
        w_low = '0;
        for (int k = N_IRQ - 1; k >= 0; k--)
            if (r_pending[k]) w_low = SW'(k);
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; an ack in the same cycle IE drops still wins, since the pipeline has already redirected.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (IE_in && |r_pending) w_next = REQ;
            REQ:        w_next = int_ack ? SAVE_EPC : (!IE_in ? IDLE : REQ);
            SAVE_EPC:   w_next = SAVE_CAUSE;
            SAVE_CAUSE: w_next = SERVICE;
            SERVICE:    if (eret) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // Pending accumulation, selected index latch on REQ entry, resume PC capture on ack.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pending <= '0;
            r_sel     <= '0;
            r_epc     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (r_state == IDLE && w_next == REQ) r_sel <= w_low;
            if (w_ack) r_epc <= pc_in;
        end
    end

    // Outputs decoded from state so reset forces them low immediately.
    always_comb begin
        int_req    = r_state == REQ;
        int_vector = int_req ? VEC_BASE + WIDTH'(r_sel) * WIDTH'(VEC_STRIDE) : '0;
        cp0_we     = (r_state == SAVE_EPC) || (r_state == SAVE_CAUSE);
        cp0_waddr  = r_state == SAVE_EPC ? CP0_EPC : (r_state == SAVE_CAUSE ? CP0_CAUSE : 5'd0);
        cp0_din    = r_state == SAVE_EPC ? r_epc
                   : (r_state == SAVE_CAUSE ? WIDTH'(w_sel_oh) << CAUSE_IP_LSB : '0);
        IE_zero    = w_ack;
        IE_one     = (r_state == SERVICE) && eret;
        in_service = r_state == SERVICE ? w_sel_oh : '0;
    end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed-vector self-checking bench for int_ctrl
module tb_int_ctrl;
    logic        clk;
    logic        clr_n;
    logic [3:0]  irq;
    logic        IE_in;
    logic [31:0] pc_in;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [31:0] int_vector;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_din;
    logic        IE_zero;
    logic        IE_one;
    logic [3:0]  in_service;
    int          n_vec = 0;
    int          n_err = 0;

    int_ctrl dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .irq        (irq),
        .IE_in      (IE_in),
        .pc_in      (pc_in),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_vector (int_vector),
        .cp0_we     (cp0_we),
        .cp0_waddr  (cp0_waddr),
        .cp0_din    (cp0_din),
        .IE_zero    (IE_zero),
        .IE_one     (IE_one),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clr_n = 1'b0; irq = '0; IE_in = 1'b0; pc_in = '0; int_ack = 1'b0; eret = 1'b0;
        #1;
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_vector", int_vector, 32'd0);
        chk("rst_cp0_we", 32'(cp0_we), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        cyc(2);
        clr_n = 1'b1;
        cyc(5);
        // irq[2] latency, vector, EPC/Cause writes
        irq = 4'b0100; IE_in = 1'b1;
        cyc(3);
        chk("lat3_int_req", 32'(int_req), 32'd0);
        cyc(1);
        chk("lat4_int_req", 32'(int_req), 32'd1);
        chk("a_vector", int_vector, 32'h0000_0820);
        cyc(2);
        chk("a_hold_req", 32'(int_req), 32'd1);
        int_ack = 1'b1; pc_in = 32'h0000_1234;
        #1;
        chk("a_ie_zero", 32'(IE_zero), 32'd1);
        cyc(1);
        int_ack = 1'b0; pc_in = '0;
        #1;
        chk("a_ie_zero_once", 32'(IE_zero), 32'd0);
        chk("a_int_req_off", 32'(int_req), 32'd0);
        chk("a_epc_we", 32'(cp0_we), 32'd1);
        chk("a_epc_addr", 32'(cp0_waddr), 32'd14);
        chk("a_epc_din", cp0_din, 32'h0000_1234);
        cyc(1);
        chk("a_cause_we", 32'(cp0_we), 32'd1);
        chk("a_cause_addr", 32'(cp0_waddr), 32'd13);
        chk("a_cause_din", cp0_din, 32'h0000_0400);
        cyc(1);
        chk("a_svc_we", 32'(cp0_we), 32'd0);
        chk("a_svc_din", cp0_din, 32'd0);
        chk("a_in_service", 32'(in_service), 32'h4);
        eret = 1'b1;
        #1;
        chk("a_ie_one", 32'(IE_one), 32'd1);
        cyc(1);
        eret = 1'b0;
        #1;
        chk("a_post_in_service", 32'(in_service), 32'd0);
        chk("a_post_ie_one", 32'(IE_one), 32'd0);
        chk("a_post_int_req", 32'(int_req), 32'd0);
        irq = '0;
        cyc(4);
        // irq[3] and irq[1] together: 1 first, then 3
        irq = 4'b1010;
        cyc(4);
        chk("b_req1", 32'(int_req), 32'd1);
        chk("b_vector1", int_vector, 32'h0000_0810);
        int_ack = 1'b1; pc_in = 32'h0000_2000;
        cyc(1);
        int_ack = 1'b0;
        cyc(1);
        chk("b_cause1", cp0_din, 32'h0000_0200);
        cyc(1);
        chk("b_svc1", 32'(in_service), 32'h2);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        #1;
        chk("b_idle_gap", 32'(int_req), 32'd0);
        cyc(1);
        chk("b_req3", 32'(int_req), 32'd1);
        chk("b_vector3", int_vector, 32'h0000_0830);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        cyc(2);
        chk("b_svc3", 32'(in_service), 32'h8);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0; irq = '0;
        cyc(4);
        // irq[0] with IE off, then IE on after 10 cycles
        IE_in = 1'b0; irq = 4'b0001;
        cyc(4);
        chk("c_masked4", 32'(int_req), 32'd0);
        cyc(6);
        chk("c_masked10", 32'(int_req), 32'd0);
        IE_in = 1'b1;
        #1;
        chk("c_not_yet", 32'(int_req), 32'd0);
        cyc(1);
        chk("c_req", 32'(int_req), 32'd1);
        chk("c_vector", int_vector, 32'h0000_0800);
        // IE dropped while requesting
        IE_in = 1'b0;
        cyc(1);
        chk("d_req_drop", 32'(int_req), 32'd0);
        chk("d_no_we", 32'(cp0_we), 32'd0);
        IE_in = 1'b1;
        cyc(1);
        chk("d_pending_kept", 32'(int_req), 32'd1);
        chk("d_vector", int_vector, 32'h0000_0800);
        // reset during SAVE_CAUSE
        int_ack = 1'b1; pc_in = 32'h0000_ABCD;
        cyc(1);
        int_ack = 1'b0;
        #1;
        chk("e_epc_din", cp0_din, 32'h0000_ABCD);
        cyc(1);
        chk("e_cause_din", cp0_din, 32'h0000_0100);
        clr_n = 1'b0;
        #1;
        chk("e_rst_we", 32'(cp0_we), 32'd0);
        chk("e_rst_addr", 32'(cp0_waddr), 32'd0);
        chk("e_rst_din", cp0_din, 32'd0);
        chk("e_rst_req", 32'(int_req), 32'd0);
        cyc(1);
        chk("e_rst_hold_we", 32'(cp0_we), 32'd0);
        clr_n = 1'b1;
        cyc(6);
        chk("e_high_irq_no_edge", 32'(int_req), 32'd0);
        chk("e_no_we_after", 32'(cp0_we), 32'd0);
        eret = 1'b1;
        #1;
        chk("e_eret_idle", 32'(IE_one), 32'd0);
        cyc(1);
        eret = 1'b0; int_ack = 1'b1;
        #1;
        chk("e_ack_idle", 32'(IE_zero), 32'd0);
        cyc(1);
        int_ack = 1'b0;
        chk("e_final_idle", 32'(int_req), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, datapath width.
REQ-002 Parameter N_IRQ, default 4, number of interrupt lines; irq[0] highest priority.
REQ-003 Parameter VEC_BASE, default 32'h0000_0800, handler vector base address.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 clr_n  in  1  reset, asynchronous, active-low.
REQ-006 irq  in  N_IRQ  asynchronous interrupt lines, rising-edge sensitive.
REQ-007 IE_in  in  1  global interrupt enable, the IE_out bit of CP0 status.
REQ-008 pc_in  in  WIDTH  resume PC presented by pipeline, valid on the int_ack cycle.
REQ-009 int_ack  in  1  pipeline flushed and redirected; sampled only while int_req=1.
REQ-010 eret  in  1  one-cycle pulse, ERET retired.
REQ-011 int_req  out  1  interrupt request to pipeline.
REQ-012 int_vector  out  WIDTH  handler address, valid while int_req=1.
REQ-013 cp0_we  out  1  CP0 write enable.
REQ-014 cp0_waddr  out  5  CP0 write register number.
REQ-015 cp0_din  out  WIDTH  CP0 write data.
REQ-016 IE_zero, IE_one  out  1 each  one-cycle pulses clearing/setting CP0 status[0].
REQ-017 in_service  out  N_IRQ  one-hot index of interrupt being serviced.

Function
REQ-018 irq SHALL pass a 2-flop synchronizer; a synchronized 0->1 transition SHALL set pending[i] next cycle.
REQ-019 pending[i] SHALL clear only when i is accepted (int_ack); a new edge on i in the clearing cycle SHALL leave pending[i]=1.
REQ-020 FSM states SHALL be IDLE, REQ, SAVE_EPC, SAVE_CAUSE, SERVICE.
REQ-021 IDLE->REQ when IE_in=1 and pending!=0; selected index sel = lowest set bit, latched on entry.
REQ-022 In REQ int_req=1 and int_vector = VEC_BASE + sel*16; sel SHALL NOT change while in REQ.
REQ-023 REQ->IDLE with int_req dropped next cycle if IE_in=0 before int_ack; pending unchanged.
REQ-024 REQ->SAVE_EPC on int_ack=1; pc_in captured, pending[sel] cleared, IE_zero pulsed that cycle.
REQ-025 SAVE_EPC: cp0_we=1, cp0_waddr=14, cp0_din=captured PC; then SAVE_CAUSE.
REQ-026 SAVE_CAUSE: cp0_we=1, cp0_waddr=13, cp0_din bits[8+N_IRQ-1:8]=one-hot sel, all others 0 (ExcCode 0); then SERVICE.
REQ-027 SERVICE: in_service=one-hot sel; new edges only accumulate in pending.
REQ-028 SERVICE->IDLE on eret=1; IE_one pulsed, in_service cleared, same cycle.
REQ-029 eret outside SERVICE SHALL be ignored; int_ack outside REQ SHALL be ignored.
REQ-030 cp0_we SHALL be 0 in every state except SAVE_EPC and SAVE_CAUSE; cp0_waddr/cp0_din 0 when cp0_we=0.
REQ-031 Interrupt-to-int_req latency: 4 cycles from irq rise with IE_in=1 and FSM idle (2 sync, 1 pending, 1 REQ).

Reset
REQ-032 clr_n=0 SHALL immediately force state IDLE, pending, sync flops, sel, captured PC and every output to 0, including mid-sequence.
REQ-033 After clr_n release, an irq already high SHALL NOT register as an edge.

Structure
REQ-034 Shared package int_pkg: state enum, CP0 register numbers 12/13/14, cause IP field offset 8, vector stride 16.
REQ-035 One sub-module irq_edge_sync (per-line synchronizer plus rising-edge detector), instantiated N_IRQ wide.

Verification
REQ-036 irq[2] rise, IE_in=1, int_ack 2 cycles after int_req, pc_in=32'h0000_1234 -> int_vector=32'h0000_0820, EPC write 32'h0000_1234, cause write 32'h0000_0400, IE_zero single pulse.
REQ-037 irq[3] and irq[1] rise same cycle -> sel=1 served first; after eret, irq[3] served with vector 32'h0000_0830.
REQ-038 irq[0] rise with IE_in=0 -> no int_req; IE_in raised 10 cycles later -> int_req next cycle.
REQ-039 IE_in dropped while in REQ before int_ack -> int_req low next cycle, pending[sel] still 1, no CP0 writes.
REQ-040 clr_n asserted during SAVE_CAUSE -> all outputs 0 same cycle, no further CP0 write; eret alone in IDLE -> no IE_one.
